// File: rtl/snake_score_tracker_pkg.sv
// Shared definitions for the snake score tracker.
//   BCD_W     : bits per BCD digit
//   LEVEL_W   : width of the level output
//   LEVEL_MAX : highest reachable level
//   to_bcd()  : turns a decimal constant into packed BCD (digit 0 in [3:0]),
//               used at elaboration time for the saturation value.
package snake_pkg;

    localparam int BCD_W     = 4;
    localparam int LEVEL_W   = 4;
    localparam int LEVEL_MAX = 15;

    function automatic logic [15:0] to_bcd(input int value);
        int          v;
        logic [15:0] r;
        v = value;
        r = '0;
        for (int i = 0; i < 4; i++) begin
            r[i*4 +: 4] = 4'(v % 10);
            v           = v / 10;
        end
        return r;
    endfunction

endpackage

// File: rtl/snake_score_tracker_if.sv
// Signal bundle between the game logic and the score tracker.
//   Game-side events : REACHED_TARGET (level), GAME_OVER, NEW_GAME, CLEAR_HIGH (pulses)
//   Tracker results  : CURRENT_SCORE, HIGH_SCORE (packed BCD), SCORE_MAX,
//                      LEVEL, LEVEL_UP, STROBE_COUNTER, DIGIT_OUT
// The event inputs are plain level/pulse signals sampled every clock; there
// is no back-pressure, the tracker consumes each event in the cycle it is seen.
// master : game logic / display side
// slave  : the tracker itself
interface snake_score_tracker_if
    import snake_pkg::*;
#(
    parameter int DIGITS = 2
);
    localparam int SW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    logic                      REACHED_TARGET;
    logic                      GAME_OVER;
    logic                      NEW_GAME;
    logic                      CLEAR_HIGH;
    logic [BCD_W*DIGITS-1:0]   CURRENT_SCORE;
    logic [BCD_W*DIGITS-1:0]   HIGH_SCORE;
    logic                      SCORE_MAX;
    logic [LEVEL_W-1:0]        LEVEL;
    logic                      LEVEL_UP;
    logic [SW-1:0]             STROBE_COUNTER;
    logic [BCD_W-1:0]          DIGIT_OUT;

    modport master (
        output REACHED_TARGET, GAME_OVER, NEW_GAME, CLEAR_HIGH,
        input  CURRENT_SCORE, HIGH_SCORE, SCORE_MAX, LEVEL, LEVEL_UP,
               STROBE_COUNTER, DIGIT_OUT
    );

    modport slave (
        input  REACHED_TARGET, GAME_OVER, NEW_GAME, CLEAR_HIGH,
        output CURRENT_SCORE, HIGH_SCORE, SCORE_MAX, LEVEL, LEVEL_UP,
               STROBE_COUNTER, DIGIT_OUT
    );

endinterface

// File: rtl/snake_score_tracker_bcd_digit_counter.sv
// One decade of the BCD score counter.
//   CLK, RESET : clock, synchronous active-high reset
//   CLR        : synchronous clear (new game)
//   INC        : an increment of the whole score is happening this cycle
//   CARRY_IN   : all lower digits are wrapping (tie to 1 for digit 0)
//   DIGIT      : registered digit value, always 0..9
//   CARRY_OUT  : this digit wraps 9 -> 0 this cycle (combinational)
module bcd_digit_counter
    import snake_pkg::*;
(
    input  logic             CLK,
    input  logic             RESET,
    input  logic             CLR,
    input  logic             INC,
    input  logic             CARRY_IN,
    output logic [BCD_W-1:0] DIGIT,
    output logic             CARRY_OUT
);

    logic [BCD_W-1:0] r_digit;
    logic             w_en;
    logic             w_is_nine;

    assign w_en      = INC & CARRY_IN;
    assign w_is_nine = (r_digit == 4'd9);
    assign CARRY_OUT = w_en & w_is_nine;
    assign DIGIT     = r_digit;

    always_ff @(posedge CLK) begin
        if (RESET || CLR) begin
            r_digit <= '0;
        end else if (w_en) begin
            r_digit <= w_is_nine ? 4'd0 : r_digit + 4'd1;
        end
    end

endmodule

// File: rtl/snake_score_tracker.sv
// Snake game score tracker.
//   CLK, RESET : clock, synchronous active-high reset (clears high score too)
//   bus        : slave side of snake_score_tracker_if
// Counts rising edges of REACHED_TARGET into a saturating BCD score, pulses
// LEVEL_UP every LEVEL_STEP accepted points, keeps a high score across games
// and scans the score digits out one at a time for a seven-segment driver.
// Event priority inside a cycle: RESET > NEW_GAME > GAME_OVER > target hit.
module snake_score_tracker
    import snake_pkg::*;
#(
    parameter int DIGITS     = 2,
    parameter int MAX_SCORE  = 99,
    parameter int LEVEL_STEP = 5,
    parameter int STROBE_DIV = 16
) (
    input  logic                  CLK,
    input  logic                  RESET,
    snake_score_tracker_if.slave  bus
);

    localparam int SCORE_W = BCD_W * DIGITS;
    localparam int SW      = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int STEP_W  = $clog2(LEVEL_STEP + 1);

    localparam logic [15:0]        MAX_BCD_FULL = to_bcd(MAX_SCORE);
    localparam logic [SCORE_W-1:0] MAX_BCD      = MAX_BCD_FULL[SCORE_W-1:0];

    logic                  r_rt_q;
    logic                  r_freeze;
    logic [STEP_W-1:0]     r_step;
    logic [LEVEL_W-1:0]    r_level;
    logic                  r_level_up;
    logic [SCORE_W-1:0]    r_high;
    logic [STROBE_DIV-1:0] r_presc;
    logic [SW-1:0]         r_strobe;

    logic                  w_hit;
    logic                  w_at_max;
    logic                  w_inc;
    logic [SCORE_W-1:0]    w_score;
    logic [DIGITS:0]       w_carry;
    logic                  w_carry_unused;
    logic [BCD_W-1:0]      w_digit;

    assign w_hit    = bus.REACHED_TARGET & ~r_rt_q;
    assign w_at_max = (w_score == MAX_BCD);

    // A hit only counts when nothing of higher priority claims the cycle.
    assign w_inc = w_hit & ~r_freeze & ~w_at_max & ~bus.NEW_GAME & ~bus.GAME_OVER;

    // Digit 0 always sees a carry-in; higher digits ripple from below.
    assign w_carry[0] = 1'b1;

    genvar g;
    for (g = 0; g < DIGITS; g++) begin : g_digit
        bcd_digit_counter u_digit (
            .CLK       (CLK),
            .RESET     (RESET),
            .CLR       (bus.NEW_GAME),
            .INC       (w_inc),
            .CARRY_IN  (w_carry[g]),
            .DIGIT     (w_score[g*BCD_W +: BCD_W]),
            .CARRY_OUT (w_carry[g+1])
        );
    end

    // Saturation below 10^DIGITS means the top carry can never fire.
    assign w_carry_unused = w_carry[DIGITS];

    // Edge register, freeze flag and level bookkeeping.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_rt_q     <= 1'b0;
            r_freeze   <= 1'b0;
            r_step     <= '0;
            r_level    <= '0;
            r_level_up <= 1'b0;
        end else begin
            r_rt_q     <= bus.REACHED_TARGET;
            r_level_up <= 1'b0;
            if (bus.NEW_GAME) begin
                r_freeze <= 1'b0;
                r_step   <= '0;
                r_level  <= '0;
            end else if (bus.GAME_OVER) begin
                r_freeze <= 1'b1;
            end else if (w_inc) begin
                if (r_step == STEP_W'(LEVEL_STEP - 1)) begin
                    r_step     <= '0;
                    r_level_up <= 1'b1;
                    if (r_level != LEVEL_W'(LEVEL_MAX)) begin
                        r_level <= r_level + 1'b1;
                    end
                end else begin
                    r_step <= r_step + 1'b1;
                end
            end
        end
    end

    // High score: CLEAR_HIGH beats a simultaneous GAME_OVER update. The BCD
    // vectors compare correctly as plain unsigned numbers.
    always_ff @(posedge CLK) begin
        if (RESET || bus.CLEAR_HIGH) begin
            r_high <= '0;
        end else if (!bus.NEW_GAME && bus.GAME_OVER && (w_score > r_high)) begin
            r_high <= w_score;
        end
    end

    // Free-running prescaler; the digit select advances when it wraps.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_presc  <= '0;
            r_strobe <= '0;
        end else begin
            r_presc <= r_presc + STROBE_DIV'(1);
            if (&r_presc) begin
                if (r_strobe == SW'(DIGITS - 1)) begin
                    r_strobe <= '0;
                end else begin
                    r_strobe <= r_strobe + 1'b1;
                end
            end
        end
    end

    always_comb begin
        w_digit = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (r_strobe == SW'(i)) begin
                w_digit = w_score[i*BCD_W +: BCD_W];
            end
        end
    end

    assign bus.CURRENT_SCORE  = w_score;
    assign bus.HIGH_SCORE     = r_high;
    assign bus.SCORE_MAX      = w_at_max;
    assign bus.LEVEL          = r_level;
    assign bus.LEVEL_UP       = r_level_up;
    assign bus.STROBE_COUNTER = r_strobe;
    assign bus.DIGIT_OUT      = w_digit;

endmodule

// File: tb/tb_snake_score_tracker.sv
// Bench for snake_score_tracker: a fixed vector table, hand-written corner
// sequences and a randomized run, all checked against an integer model.
module tb_snake_score_tracker;

    localparam int DIGITS     = 2;
    localparam int MAX_SCORE  = 99;
    localparam int LEVEL_STEP = 5;
    localparam int STROBE_DIV = 2;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    snake_score_tracker_if #(.DIGITS(DIGITS)) bus ();

    snake_score_tracker #(
        .DIGITS     (DIGITS),
        .MAX_SCORE  (MAX_SCORE),
        .LEVEL_STEP (LEVEL_STEP),
        .STROBE_DIV (STROBE_DIV)
    ) dut (
        .CLK   (clk),
        .RESET (rst),
        .bus   (bus)
    );

    int n_vec = 0;
    int n_err = 0;

    // Reference model state, plain integers.
    int m_score, m_high, m_level, m_step, m_freeze, m_rtq, m_lu, m_cyc;
    int lu_seen;

    function automatic int to_bcd_i(input int v);
        int r;
        int x;
        r = 0;
        x = v;
        for (int d = 0; d < DIGITS; d++) begin
            r = r + ((x % 10) << (4 * d));
            x = x / 10;
        end
        return r;
    endfunction

    task automatic model_update(input logic r, input logic rt, input logic go,
                                input logic ng, input logic ch);
        int hit;
        if (r) begin
            m_score = 0; m_high = 0; m_level = 0; m_step = 0;
            m_freeze = 0; m_rtq = 0; m_lu = 0; m_cyc = 0;
        end else begin
            hit  = (rt && !m_rtq) ? 1 : 0;
            m_lu = 0;
            if (ng) begin
                m_score = 0; m_step = 0; m_level = 0; m_freeze = 0;
            end else if (go) begin
                m_freeze = 1;
                if (m_score > m_high) m_high = m_score;
            end else if (hit == 1 && m_freeze == 0 && m_score < MAX_SCORE) begin
                m_score++;
                m_step++;
                if (m_step == LEVEL_STEP) begin
                    m_step = 0;
                    m_lu   = 1;
                    if (m_level < 15) m_level++;
                end
            end
            if (ch) m_high = 0;
            m_rtq = rt ? 1 : 0;
            m_cyc++;
        end
    endtask

    task automatic check_model();
        int strobe;
        int e_digit;
        strobe  = (m_cyc >> STROBE_DIV) % DIGITS;
        e_digit = (to_bcd_i(m_score) >> (4 * strobe)) & 15;
        n_vec++;
        if (bus.CURRENT_SCORE !== 8'(to_bcd_i(m_score)) ||
            bus.HIGH_SCORE !== 8'(to_bcd_i(m_high)) ||
            bus.SCORE_MAX !== (m_score == MAX_SCORE) ||
            bus.LEVEL !== 4'(m_level) ||
            bus.LEVEL_UP !== (m_lu == 1) ||
            bus.STROBE_COUNTER !== 1'(strobe) ||
            bus.DIGIT_OUT !== 4'(e_digit)) begin
            n_err++;
            $display("FAIL model t=%0t score=%h/%h high=%h/%h max=%b/%0d lvl=%0d/%0d lu=%b/%0d strobe=%0d/%0d digit=%0d/%0d (actual/required)",
                     $time, bus.CURRENT_SCORE, to_bcd_i(m_score), bus.HIGH_SCORE, to_bcd_i(m_high),
                     bus.SCORE_MAX, (m_score == MAX_SCORE), bus.LEVEL, m_level, bus.LEVEL_UP, m_lu,
                     bus.STROBE_COUNTER, strobe, bus.DIGIT_OUT, e_digit);
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // One clock: drive inputs, take the edge, advance the model, compare.
    task automatic step(input logic r, input logic rt, input logic go,
                        input logic ng, input logic ch);
        rst                = r;
        bus.REACHED_TARGET = rt;
        bus.GAME_OVER      = go;
        bus.NEW_GAME       = ng;
        bus.CLEAR_HIGH     = ch;
        @(posedge clk);
        model_update(r, rt, go, ng, ch);
        #1;
        check_model();
        if (bus.LEVEL_UP === 1'b1) lu_seen++;
    endtask

    task automatic hit();
        step(0, 1, 0, 0, 0);
        step(0, 0, 0, 0, 0);
    endtask

    task automatic do_reset();
        step(1, 0, 0, 0, 0);
    endtask

    typedef struct {
        logic       r, rt, go, ng, ch;
        logic [7:0] e_score;
        logic [7:0] e_high;
        logic [3:0] e_level;
        logic       e_lu;
    } vec_t;

    vec_t tbl[13];

    initial begin
        m_score = 0; m_high = 0; m_level = 0; m_step = 0;
        m_freeze = 0; m_rtq = 0; m_lu = 0; m_cyc = 0; lu_seen = 0;
        rst = 1'b1;
        bus.REACHED_TARGET = 1'b0;
        bus.GAME_OVER = 1'b0;
        bus.NEW_GAME = 1'b0;
        bus.CLEAR_HIGH = 1'b0;

        //        r  rt go ng ch  score  high  lvl lu
        tbl[0]  = '{1, 0, 0, 0, 0, 8'h00, 8'h00, 0, 0};
        tbl[1]  = '{0, 1, 0, 0, 0, 8'h01, 8'h00, 0, 0};
        tbl[2]  = '{0, 0, 0, 0, 0, 8'h01, 8'h00, 0, 0};
        tbl[3]  = '{0, 1, 0, 0, 0, 8'h02, 8'h00, 0, 0};
        tbl[4]  = '{0, 0, 0, 0, 0, 8'h02, 8'h00, 0, 0};
        tbl[5]  = '{0, 1, 0, 0, 0, 8'h03, 8'h00, 0, 0};
        tbl[6]  = '{0, 1, 0, 0, 0, 8'h03, 8'h00, 0, 0};
        tbl[7]  = '{0, 0, 0, 0, 0, 8'h03, 8'h00, 0, 0};
        tbl[8]  = '{0, 0, 1, 0, 0, 8'h03, 8'h03, 0, 0};
        tbl[9]  = '{0, 1, 0, 0, 0, 8'h03, 8'h03, 0, 0};
        tbl[10] = '{0, 0, 0, 1, 0, 8'h00, 8'h03, 0, 0};
        tbl[11] = '{0, 1, 1, 0, 0, 8'h00, 8'h03, 0, 0};
        tbl[12] = '{0, 0, 0, 0, 1, 8'h00, 8'h00, 0, 0};

        for (int i = 0; i < 13; i++) begin
            step(tbl[i].r, tbl[i].rt, tbl[i].go, tbl[i].ng, tbl[i].ch);
            check($sformatf("tbl%0d_score", i), 32'(bus.CURRENT_SCORE), 32'(tbl[i].e_score));
            check($sformatf("tbl%0d_high", i), 32'(bus.HIGH_SCORE), 32'(tbl[i].e_high));
            check($sformatf("tbl%0d_level", i), 32'(bus.LEVEL), 32'(tbl[i].e_level));
            check($sformatf("tbl%0d_lu", i), 32'(bus.LEVEL_UP), 32'(tbl[i].e_lu));
        end

        // Held-high target scores once.
        do_reset();
        for (int i = 0; i < 20; i++) step(0, 1, 0, 0, 0);
        check("held_high_score", 32'(bus.CURRENT_SCORE), 32'h01);
        step(0, 0, 0, 0, 0);

        // Digit carry 09 -> 10.
        do_reset();
        for (int i = 0; i < 9; i++) hit();
        check("pre_carry", 32'(bus.CURRENT_SCORE), 32'h09);
        hit();
        check("carry", 32'(bus.CURRENT_SCORE), 32'h10);

        // Level pulses: 10 hits give exactly two LEVEL_UP cycles.
        do_reset();
        lu_seen = 0;
        for (int i = 0; i < 10; i++) hit();
        check("level_up_count", 32'(lu_seen), 32'd2);
        check("level_after_10", 32'(bus.LEVEL), 32'd2);

        // Saturation at 99; level saturates at 15 on the way.
        do_reset();
        for (int i = 0; i < 98; i++) hit();
        check("preload_98", 32'(bus.CURRENT_SCORE), 32'h98);
        check("max_low_at_98", 32'(bus.SCORE_MAX), 32'd0);
        for (int i = 0; i < 3; i++) hit();
        check("sat_score", 32'(bus.CURRENT_SCORE), 32'h99);
        check("sat_flag", 32'(bus.SCORE_MAX), 32'd1);
        check("sat_level", 32'(bus.LEVEL), 32'd15);

        // Game over, freeze, new game keeps high score, reset clears all.
        do_reset();
        for (int i = 0; i < 12; i++) hit();
        step(0, 0, 1, 0, 0);
        check("go_high", 32'(bus.HIGH_SCORE), 32'h12);
        hit();
        check("frozen_score", 32'(bus.CURRENT_SCORE), 32'h12);
        step(0, 0, 0, 1, 0);
        for (int i = 0; i < 4; i++) hit();
        step(0, 0, 1, 0, 0);
        check("high_kept", 32'(bus.HIGH_SCORE), 32'h12);
        check("score_4", 32'(bus.CURRENT_SCORE), 32'h04);
        do_reset();
        check("rst_score", 32'(bus.CURRENT_SCORE), 32'h00);
        check("rst_high", 32'(bus.HIGH_SCORE), 32'h00);
        check("rst_level", 32'(bus.LEVEL), 32'd0);

        // Game over coinciding with a hit.
        for (int i = 0; i < 7; i++) hit();
        step(0, 1, 1, 0, 0);
        check("go_hit_high", 32'(bus.HIGH_SCORE), 32'h07);
        check("go_hit_score", 32'(bus.CURRENT_SCORE), 32'h07);

        // Clear-high together with game over.
        step(0, 0, 0, 1, 0);
        for (int i = 0; i < 9; i++) hit();
        step(0, 0, 1, 0, 1);
        check("clear_beats_go", 32'(bus.HIGH_SCORE), 32'h00);

        // Display scan of 42: digits 2 and 4 alternate every 4 cycles.
        do_reset();
        for (int i = 0; i < 42; i++) hit();
        for (int i = 0; i < 16; i++) step(0, 0, 0, 0, 0);

        // Randomized run against the model.
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 299) == 0,
                 $urandom_range(0, 2) == 0,
                 $urandom_range(0, 59) == 0,
                 $urandom_range(0, 89) == 0,
                 $urandom_range(0, 149) == 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/snake_score_tracker.md
Name: snake_score_tracker

Overview:
Parametrised score tracker for the snake game. It counts rising edges of the target-reached indication into a saturating multi-digit BCD score, and raises a level-up pulse every LEVEL_STEP points. It also keeps a high score across games and time-multiplexes the score digits for the seven-segment driver. It sits between the game-logic FSM (target, game-over, new-game events) and the display/speed-control logic.

Parameters:
DIGITS, 2, number of BCD digits in score and high score (1..4)
MAX_SCORE, 99, saturation value in decimal; must be < 10^DIGITS
LEVEL_STEP, 5, points per level-up (1..MAX_SCORE)
STROBE_DIV, 16, prescaler width; digit select advances every 2^STROBE_DIV cycles

Ports:
CLK  in  1  system clock
RESET  in  1  synchronous, active-high; clears all state including high score
REACHED_TARGET  in  1  level from game FSM; each rising edge scores one point
GAME_OVER  in  1  single-cycle pulse; freezes score and updates high score
NEW_GAME  in  1  single-cycle pulse; clears score/level/freeze, keeps high score
CLEAR_HIGH  in  1  single-cycle pulse; clears high score
CURRENT_SCORE  out  4*DIGITS  BCD score, digit 0 in bits [3:0]
HIGH_SCORE  out  4*DIGITS  BCD high score
SCORE_MAX  out  1  high while CURRENT_SCORE == MAX_SCORE
LEVEL  out  4  current level, 0..15
LEVEL_UP  out  1  one-cycle pulse on level increment
STROBE_COUNTER  out  max(1,$clog2(DIGITS))  active digit index
DIGIT_OUT  out  4  BCD digit of CURRENT_SCORE selected by STROBE_COUNTER

Behaviour:
- Reset (RESET=1 at a CLK edge): all outputs 0, edge register 0, freeze 0, step counter 0, prescaler 0.
- Edge detect: rt_q <= REACHED_TARGET each cycle; hit = REACHED_TARGET & ~rt_q. Everything is synchronous to CLK; no other clock domains.
- Increment: on a cycle with hit=1, freeze=0 and score != MAX_SCORE, CURRENT_SCORE increments by 1 in BCD at that same edge, so it is visible one cycle after REACHED_TARGET is first sampled high. A held-high REACHED_TARGET scores once.
- BCD arithmetic: a digit equal to 9 wraps to 0 with carry into the next digit. Digits never exceed 9.
- Saturation: at MAX_SCORE, hits are ignored and SCORE_MAX=1. The step counter and LEVEL stop changing.
- Level: the step counter counts 0..LEVEL_STEP-1 on each accepted increment. When it wraps, LEVEL_UP=1 for the following cycle and LEVEL increments, saturating at 15. At saturation LEVEL_UP still pulses, but LEVEL holds.
- GAME_OVER: freeze <= 1. If CURRENT_SCORE > HIGH_SCORE (unsigned compare of the BCD vectors, which is order-preserving), HIGH_SCORE <= CURRENT_SCORE. The comparison uses the pre-increment score.
- NEW_GAME: score, step counter, LEVEL, freeze <= 0. HIGH_SCORE is kept. rt_q still updates, so a target held high through NEW_GAME does not score.
- Priority within one cycle: RESET > NEW_GAME > GAME_OVER > hit.
  - A hit coinciding with GAME_OVER or NEW_GAME is dropped.
  - CLEAR_HIGH with GAME_OVER: the clear wins and HIGH_SCORE becomes 0.
- Display: the prescaler free-runs. On prescaler wrap (all ones to 0), STROBE_COUNTER advances modulo DIGITS.
- DIGIT_OUT is combinational from STROBE_COUNTER and CURRENT_SCORE.
- For DIGITS=1, STROBE_COUNTER stays 0.

Decomposition:
- Shared package snake_pkg holds:
  - BCD_W = 4
  - LEVEL_W = 4
  - LEVEL_MAX = 15
  - function to_bcd(int) for elaborating MAX_SCORE into a BCD constant
- Sub-module bcd_digit_counter: one per digit, generated DIGITS times.
  - Ports: CLK, RESET, CLR, INC, CARRY_IN.
  - Registered DIGIT output; combinational CARRY_OUT when DIGIT==9 and enabled.

Test Plan:
1. Reset, then 3 separate REACHED_TARGET pulses, each high 1 cycle → CURRENT_SCORE=0x03; each update lands 1 cycle after the rising edge.
2. REACHED_TARGET held high 20 cycles → score increments exactly once.
3. Score at 0x09, one hit → 0x10 (digit carry). Preload to 0x98, three hits → 0x99, SCORE_MAX=1, stays 0x99.
4. LEVEL_STEP=5, 10 hits → LEVEL_UP pulses exactly twice, each 1 cycle wide, after hits 5 and 10; LEVEL=2.
5. Score 0x12, GAME_OVER → HIGH_SCORE=0x12; further hits ignored. NEW_GAME, 4 hits, GAME_OVER → HIGH_SCORE stays 0x12. Then RESET → all 0.
6. GAME_OVER and a hit in the same cycle with score 0x07 → HIGH_SCORE=0x07 and score stays 0x07. With STROBE_DIV=2 and score 0x42 → DIGIT_OUT alternates 2,4 every 4 cycles.
